// File: rtl/pcie_host_if_pattern_tester.sv
// Pattern traffic generator and loopback checker for the PCIe host interface data path.
// Generator and checker each own a pattern register that advances only on its own handshake.
module pcie_host_if_pattern_tester #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned COUNT_WIDTH = 16,
  parameter int unsigned ERR_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [1:0]             i_mode,
  input  logic [DATA_WIDTH-1:0]  i_seed,
  input  logic [COUNT_WIDTH-1:0] i_count,
  output logic [DATA_WIDTH-1:0]  o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  input  logic [DATA_WIDTH-1:0]  i_rx_data,
  input  logic                   i_rx_valid,
  output logic                   o_rx_ready,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [ERR_WIDTH-1:0]   o_err_count,
  output logic [DATA_WIDTH-1:0]  o_first_err_data,
  output logic [COUNT_WIDTH-1:0] o_first_err_index,
  output logic [COUNT_WIDTH-1:0] o_tx_words,
  output logic [COUNT_WIDTH-1:0] o_rx_words
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 r_state;
  state_e                 w_state_next;
  logic [1:0]             r_mode;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [DATA_WIDTH-1:0]  r_tx_pat;
  logic [DATA_WIDTH-1:0]  r_rx_pat;
  logic [COUNT_WIDTH-1:0] r_tx_words;
  logic [COUNT_WIDTH-1:0] r_rx_words;
  logic [ERR_WIDTH-1:0]   r_err_count;
  logic [DATA_WIDTH-1:0]  r_first_err_data;
  logic [COUNT_WIDTH-1:0] r_first_err_index;

  logic                  w_start_ok;
  logic                  w_tx_fire;
  logic                  w_rx_fire;
  logic                  w_all_done;
  logic [DATA_WIDTH-1:0] w_tx_word;
  logic [DATA_WIDTH-1:0] w_rx_expect;
  logic                  w_mismatch;

  // Pattern registers hold S+n (modes 0/1), S (mode 2) or rotl(S,n) (mode 3).
  function automatic logic [DATA_WIDTH-1:0] next_pat(input logic [1:0] mode,
                                                     input logic [DATA_WIDTH-1:0] pat);
    logic [DATA_WIDTH-1:0] res;
    unique case (mode)
      2'd0, 2'd1: res = pat + DATA_WIDTH'(1);
      2'd2:       res = pat;
      default:    res = {pat[DATA_WIDTH-2:0], pat[DATA_WIDTH-1]};
    endcase
    return res;
  endfunction

  // Mode 1 is stored as the plain increment and inverted on the way out.
  assign w_tx_word   = (r_mode == 2'd1) ? ~r_tx_pat : r_tx_pat;
  assign w_rx_expect = (r_mode == 2'd1) ? ~r_rx_pat : r_rx_pat;

  assign w_start_ok = i_start && !i_abort && (r_state != StRun);
  assign w_tx_fire  = o_tx_valid && i_tx_ready;
  assign w_rx_fire  = i_rx_valid && o_rx_ready;
  assign w_all_done = (r_tx_words == r_count) && (r_rx_words == r_count);
  assign w_mismatch = w_rx_fire && (i_rx_data != w_rx_expect);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (i_abort) begin
      w_state_next = StIdle;
    end else begin
      case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            w_state_next = (i_count == '0) ? StDone : StRun;
          end
        end
        StRun: begin
          if (w_all_done) begin
            w_state_next = StDone;
          end
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_comb begin
    o_busy     = 1'b0;
    o_done     = 1'b0;
    o_tx_valid = 1'b0;
    o_rx_ready = 1'b0;
    case (r_state)
      StRun: begin
        o_busy     = 1'b1;
        o_tx_valid = (r_tx_words < r_count);
        o_rx_ready = (r_rx_words < r_count);
      end
      StDone:  o_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode            <= 2'd0;
      r_count           <= '0;
      r_tx_pat          <= '0;
      r_rx_pat          <= '0;
      r_tx_words        <= '0;
      r_rx_words        <= '0;
      r_err_count       <= '0;
      r_first_err_data  <= '0;
      r_first_err_index <= '0;
    end else if (w_start_ok) begin
      r_mode            <= i_mode;
      r_count           <= i_count;
      r_tx_pat          <= i_seed;
      r_rx_pat          <= i_seed;
      r_tx_words        <= '0;
      r_rx_words        <= '0;
      r_err_count       <= '0;
      r_first_err_data  <= '0;
      r_first_err_index <= '0;
    end else begin
      if (w_tx_fire) begin
        r_tx_words <= r_tx_words + COUNT_WIDTH'(1);
        r_tx_pat   <= next_pat(r_mode, r_tx_pat);
      end
      if (w_rx_fire) begin
        r_rx_words <= r_rx_words + COUNT_WIDTH'(1);
        r_rx_pat   <= next_pat(r_mode, r_rx_pat);
      end
      if (w_mismatch) begin
        // A zero count means no error has been seen since start.
        if (r_err_count == '0) begin
          r_first_err_data  <= i_rx_data;
          r_first_err_index <= r_rx_words;
        end
        if (r_err_count != '1) begin
          r_err_count <= r_err_count + ERR_WIDTH'(1);
        end
      end
    end
  end

  assign o_tx_data         = w_tx_word;
  assign o_err_count       = r_err_count;
  assign o_first_err_data  = r_first_err_data;
  assign o_first_err_index = r_first_err_index;
  assign o_tx_words        = r_tx_words;
  assign o_rx_words        = r_rx_words;

endmodule

// File: tb/tb_pcie_host_if_pattern_tester.sv
// Randomized loopback bench for pcie_host_if_pattern_tester with a queue-based reference model.
module tb_pcie_host_if_pattern_tester;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic [1:0]    i_mode = 2'd0;
  logic [DW-1:0] i_seed = '0;
  logic [CW-1:0] i_count = '0;
  logic [DW-1:0] o_tx_data;
  logic          o_tx_valid;
  logic          i_tx_ready = 1'b0;
  logic [DW-1:0] i_rx_data = '0;
  logic          i_rx_valid = 1'b0;
  logic          o_rx_ready;
  logic          o_busy;
  logic          o_done;
  logic [EW-1:0] o_err_count;
  logic [DW-1:0] o_first_err_data;
  logic [CW-1:0] o_first_err_index;
  logic [CW-1:0] o_tx_words;
  logic [CW-1:0] o_rx_words;

  int checks = 0;
  int failures = 0;

  pcie_host_if_pattern_tester #(
    .DATA_WIDTH (DW),
    .COUNT_WIDTH(CW),
    .ERR_WIDTH  (EW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_start          (i_start),
    .i_abort          (i_abort),
    .i_mode           (i_mode),
    .i_seed           (i_seed),
    .i_count          (i_count),
    .o_tx_data        (o_tx_data),
    .o_tx_valid       (o_tx_valid),
    .i_tx_ready       (i_tx_ready),
    .i_rx_data        (i_rx_data),
    .i_rx_valid       (i_rx_valid),
    .o_rx_ready       (o_rx_ready),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_err_count      (o_err_count),
    .o_first_err_data (o_first_err_data),
    .o_first_err_index(o_first_err_index),
    .o_tx_words       (o_tx_words),
    .o_rx_words       (o_rx_words)
  );

  always #5 clk = ~clk;

  // Word n of the test pattern, straight from the pattern definitions.
  function automatic logic [DW-1:0] ref_word(input int mode, input logic [DW-1:0] s, input int n);
    logic [DW-1:0] sum;
    int k;
    sum = s + DW'(n);
    k = n % DW;
    case (mode)
      0: return sum;
      1: return ~sum;
      2: return s;
      default: return (k == 0) ? s : ((s << k) | (s >> (DW - k)));
    endcase
  endfunction

  // Called at a negedge; leaves the bench at the following negedge.
  task automatic start_test(input int mode, input logic [DW-1:0] seed, input int cnt);
    i_mode     = 2'(mode);
    i_seed     = seed;
    i_count    = CW'(cnt);
    i_tx_ready = 1'b0;
    i_rx_valid = 1'b0;
    i_start    = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // corrupt: -1 none, -2 every word inverted, >=0 that index forced to zero.
  task automatic run_test(input string name, input int mode, input logic [DW-1:0] seed,
                          input int cnt, input bit rdy_rand, input bit vld_rand,
                          input int corrupt, input int budget);
    logic [DW-1:0] q[$];
    logic [DW-1:0] w;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] exp_fd;
    bit            prev_stall;
    bit            seen_done;
    int            tx_n, rx_n, exp_err, exp_fi, exp_sat;
    tx_n = 0; rx_n = 0; exp_err = 0; exp_fd = '0; exp_fi = 0;
    prev_stall = 0; prev_data = '0; seen_done = 0;
    start_test(mode, seed, cnt);
    for (int c = 0; c < budget && !seen_done; c++) begin
      i_tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (q.size() > 0 && (!vld_rand || $urandom_range(0, 1) == 1)) begin
        i_rx_valid = 1'b1;
        i_rx_data  = q[0];
      end else begin
        i_rx_valid = 1'b0;
        i_rx_data  = $urandom;
      end
      #1;
      if (o_done) begin
        seen_done = 1;
      end else begin
        checks++;
        if (o_busy !== 1'b1) begin
          failures++;
          $display("FAIL %s busy: got %0b want 1 (cycle %0d)", name, o_busy, c);
        end
        checks++;
        if (o_tx_valid !== (tx_n < cnt)) begin
          failures++;
          $display("FAIL %s tx_valid: got %0b want %0b (tx %0d)", name, o_tx_valid,
                   (tx_n < cnt), tx_n);
        end
        checks++;
        if (o_rx_ready !== (rx_n < cnt)) begin
          failures++;
          $display("FAIL %s rx_ready: got %0b want %0b (rx %0d)", name, o_rx_ready,
                   (rx_n < cnt), rx_n);
        end
        if (prev_stall) begin
          checks++;
          if (o_tx_data !== prev_data) begin
            failures++;
            $display("FAIL %s stall_stable: got %08h want %08h", name, o_tx_data, prev_data);
          end
        end
        if (o_tx_valid && i_tx_ready) begin
          checks++;
          if (o_tx_data !== ref_word(mode, seed, tx_n)) begin
            failures++;
            $display("FAIL %s tx_data[%0d]: got %08h want %08h", name, tx_n, o_tx_data,
                     ref_word(mode, seed, tx_n));
          end
          w = ref_word(mode, seed, tx_n);
          if (corrupt == -2) w = ~w;
          else if (corrupt == tx_n) w = '0;
          q.push_back(w);
          tx_n++;
        end
        if (i_rx_valid && o_rx_ready) begin
          w = q.pop_front();
          if (w != ref_word(mode, seed, rx_n)) begin
            if (exp_err == 0) begin
              exp_fd = w;
              exp_fi = rx_n;
            end
            exp_err++;
          end
          rx_n++;
        end
        prev_stall = o_tx_valid && !i_tx_ready;
        prev_data  = o_tx_data;
      end
      @(negedge clk);
    end
    i_tx_ready = 1'b0;
    i_rx_valid = 1'b0;
    exp_sat = (exp_err > 255) ? 255 : exp_err;
    checks++;
    if (!seen_done) begin
      failures++;
      $display("FAIL %s done: got timeout want done within %0d cycles", name, budget);
    end
    checks++;
    if (o_err_count !== EW'(exp_sat)) begin
      failures++;
      $display("FAIL %s err_count: got %0d want %0d", name, o_err_count, exp_sat);
    end
    checks++;
    if (o_first_err_data !== exp_fd) begin
      failures++;
      $display("FAIL %s first_err_data: got %08h want %08h", name, o_first_err_data, exp_fd);
    end
    checks++;
    if (o_first_err_index !== CW'(exp_fi)) begin
      failures++;
      $display("FAIL %s first_err_index: got %0d want %0d", name, o_first_err_index, exp_fi);
    end
    checks++;
    if (o_tx_words !== CW'(cnt) || o_rx_words !== CW'(cnt)) begin
      failures++;
      $display("FAIL %s words: got tx %0d rx %0d want %0d", name, o_tx_words, o_rx_words, cnt);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({o_tx_data, o_tx_valid, o_rx_ready, o_busy, o_done, o_err_count, o_first_err_data,
         o_first_err_index, o_tx_words, o_rx_words} !== '0) begin
      failures++;
      $display("FAIL %s outputs: got tx_data %08h valid %0b ready %0b busy %0b done %0b err %0d txw %0d rxw %0d want all 0",
               name, o_tx_data, o_tx_valid, o_rx_ready, o_busy, o_done, o_err_count,
               o_tx_words, o_rx_words);
    end
  endtask

  task automatic test_reset();
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset_release");
  endtask

  task automatic test_mode0();
    run_test("mode0", 0, 32'hFFFF_FFFE, 4, 1'b0, 1'b0, -1, 100);
  endtask

  task automatic test_walking_backpressure();
    run_test("mode3_bp", 3, 32'h0000_0001, 34, 1'b1, 1'b1, -1, 1000);
  endtask

  task automatic test_single_error();
    run_test("mode2_err", 2, 32'hA5A5_A5A5, 8, 1'b0, 1'b0, 5, 200);
  endtask

  task automatic test_saturate();
    run_test("mode1_sat", 1, 32'h1234_0000, 300, 1'b0, 1'b0, -2, 2000);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      run_test("random", int'($urandom_range(0, 3)), $urandom, int'($urandom_range(1, 40)),
               1'b1, 1'b1, -1, 1000);
    end
  endtask

  task automatic test_count_zero();
    start_test(0, 32'h5, 0);
    checks++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_tx_valid !== 1'b0 || o_rx_ready !== 1'b0) begin
      failures++;
      $display("FAIL count0: got done %0b busy %0b valid %0b ready %0b want 1 0 0 0",
               o_done, o_busy, o_tx_valid, o_rx_ready);
    end
  endtask

  task automatic test_abort();
    int n;
    n = 0;
    start_test(0, 32'h100, 10);
    for (int c = 0; c < 20 && n < 3; c++) begin
      i_tx_ready = 1'b1;
      #1;
      if (o_tx_valid && i_tx_ready) n++;
      @(negedge clk);
    end
    i_tx_ready = 1'b0;
    i_abort    = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_tx_valid !== 1'b0 || o_rx_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_state: got busy %0b done %0b valid %0b ready %0b want 0 0 0 0",
               o_busy, o_done, o_tx_valid, o_rx_ready);
    end
    checks++;
    if (o_tx_words !== CW'(n) || n != 3) begin
      failures++;
      $display("FAIL abort_tx_words: got %0d want 3 (bench sent %0d)", o_tx_words, n);
    end
    // Abort beats a simultaneous start.
    i_count = CW'(5);
    i_start = 1'b1;
    i_abort = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_abort = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_tx_words !== CW'(3)) begin
      failures++;
      $display("FAIL abort_wins: got busy %0b done %0b tx_words %0d want 0 0 3",
               o_busy, o_done, o_tx_words);
    end
  endtask

  task automatic test_async_reset();
    start_test(0, 32'hDEAD_0000, 20);
    i_tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    i_tx_ready = 1'b0;
    @(negedge clk);
    check_all_zero("async_reset_idle");
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_walking_backpressure();
    test_single_error();
    test_saturate();
    test_random();
    test_count_zero();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
